// File: rtl/multi_port_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multi_port_sram_pkg
//  Purpose  : Shared helpers for the banked multi-port SRAM: address-to-bank
//             and address-to-row mapping, the rotating-priority pick used by
//             the per-bank arbiters, and parameter sanity checks evaluated at
//             elaboration time.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package multi_port_sram_pkg;

  // Upper bound on the port count; sizes the request vector of rr_pick.
  localparam int MAX_PORTS = 32;

  // Low-order interleave: consecutive words land in consecutive banks.
  // BANKS is a power of two, so % and / reduce to bit slicing.
  function automatic int bank_of(input int addr, input int banks);
    return addr % banks;
  endfunction

  function automatic int row_of(input int addr, input int banks);
    return addr / banks;
  endfunction

  // First asserted request at or after ptr, wrapping modulo ports.
  // Returns ports when nothing is requested.
  function automatic int rr_pick(input logic [MAX_PORTS-1:0] req,
                                 input int ptr, input int ports);
    int idx;
    bit found;
    rr_pick = ports;
    found   = 1'b0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      if (k < ports && !found) begin
        idx = (ptr + k) % ports;
        if (req[idx]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Each bank must hold at least two rows so the row index is never empty.
  function automatic bit params_ok(input int n, input int banks, input int ports);
    return is_pow2(banks) && (ports >= 1) && (ports <= MAX_PORTS) &&
           (n % banks == 0) && (n / banks >= 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_port_sram_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : multi_port_sram_rr_arb
//  Purpose  : P-input round-robin arbiter for one SRAM bank. Grants the first
//             requester at or after the pointer; the pointer moves past the
//             winner on each grant and holds otherwise.
//  Ports    : clk, rst_n (sync, active low), req[P] in, gnt[P] out (one-hot
//             or zero, forced to zero while in reset)
//  Revision : 1.0 - initial release
// ============================================================================
module multi_port_sram_rr_arb
  import multi_port_sram_pkg::*;
#(
  parameter int P = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [P-1:0] req,
  output logic [P-1:0] gnt
);

  localparam int PW = (P > 1) ? $clog2(P) : 1;

  logic [PW-1:0]        r_ptr;
  logic [MAX_PORTS-1:0] w_req_ext;
  int                   w_pick;

  assign w_req_ext = MAX_PORTS'(req);

  always_comb begin
    w_pick = rr_pick(w_req_ext, int'(r_ptr), P);
    gnt    = '0;
    for (int i = 0; i < P; i++) begin
      gnt[i] = rst_n && (w_pick == i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_pick < P) begin
      r_ptr <= PW'((w_pick + 1) % P);
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_port_sram_banked.sv
`default_nettype none
// ============================================================================
//  Module   : multi_port_sram_banked
//  Purpose  : P-port SRAM built from BANKS single-port banks with low-order
//             address interleaving. Each bank takes one access per cycle,
//             chosen by its own round-robin arbiter. Reads return one cycle
//             after acceptance; writes produce no response.
//  Ports    : clk, rst_n (sync, active low)
//             req_valid[P], req_we[P], req_addr[P*AW], req_wdata[P*W] in
//             req_ready[P] out (combinational grant)
//             rsp_valid[P], rsp_rdata[P*W] out (registered read response)
//  Revision : 1.0 - initial release
// ============================================================================
module multi_port_sram_banked
  import multi_port_sram_pkg::*;
#(
  parameter  int W     = 32,
  parameter  int N     = 256,
  parameter  int BANKS = 4,
  parameter  int P     = 2,
  localparam int AW    = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [P-1:0]   req_valid,
  output logic [P-1:0]   req_ready,
  input  logic [P-1:0]   req_we,
  input  logic [P*AW-1:0] req_addr,
  input  logic [P*W-1:0] req_wdata,
  output logic [P-1:0]   rsp_valid,
  output logic [P*W-1:0] rsp_rdata
);

  localparam int DEPTH = N / BANKS;
  localparam int RW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BIW   = (BANKS > 1) ? $clog2(BANKS) : 1;

  if (!params_ok(N, BANKS, P)) begin : g_param_error
    $error("multi_port_sram_banked: illegal W/N/BANKS/P combination");
  end

  logic [BIW-1:0] w_port_bank  [P];
  logic [RW-1:0]  w_port_row   [P];
  logic [P-1:0]   w_gnt        [BANKS];
  logic [W-1:0]   w_bank_rdata [BANKS];

  logic [P-1:0]   r_rsp_valid;
  logic [P*W-1:0] r_rsp_rdata;

  always_comb begin
    for (int i = 0; i < P; i++) begin
      w_port_bank[i] = BIW'(bank_of(int'(req_addr[i*AW +: AW]), BANKS));
      w_port_row[i]  = RW'(row_of(int'(req_addr[i*AW +: AW]), BANKS));
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [P-1:0] w_req;
    logic         w_hit;
    logic         w_we;
    logic [RW-1:0] w_row;
    logic [W-1:0] w_wdata;
    logic [W-1:0] r_mem [DEPTH];

    always_comb begin
      for (int i = 0; i < P; i++) begin
        w_req[i] = req_valid[i] && (w_port_bank[i] == BIW'(b));
      end
    end

    multi_port_sram_rr_arb #(.P(P)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (w_req),
      .gnt   (w_gnt[b])
    );

    // Grant is one-hot, so at most one port drives the bank access.
    always_comb begin
      w_hit   = 1'b0;
      w_we    = 1'b0;
      w_row   = '0;
      w_wdata = '0;
      for (int i = 0; i < P; i++) begin
        if (w_gnt[b][i]) begin
          w_hit   = 1'b1;
          w_we    = req_we[i];
          w_row   = w_port_row[i];
          w_wdata = req_wdata[i*W +: W];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (w_hit && w_we) begin
        r_mem[w_row] <= w_wdata;
      end
    end

    // Row contents before this edge's write; captured by the port register.
    assign w_bank_rdata[b] = r_mem[w_row];
  end

  always_comb begin
    req_ready = '0;
    for (int b = 0; b < BANKS; b++) begin
      for (int i = 0; i < P; i++) begin
        req_ready[i] = req_ready[i] | w_gnt[b][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      for (int i = 0; i < P; i++) begin
        r_rsp_valid[i] <= req_valid[i] && req_ready[i] && !req_we[i];
        if (req_valid[i] && req_ready[i] && !req_we[i]) begin
          r_rsp_rdata[i*W +: W] <= w_bank_rdata[w_port_bank[i]];
        end
      end
    end
  end

  // Gating with rst_n drops a response whose read was accepted just before
  // reset: it never becomes visible.
  assign rsp_valid = r_rsp_valid & {P{rst_n}};
  assign rsp_rdata = r_rsp_rdata;

  // Only reachable when N is not a power of two.
  always @(posedge clk) begin
    for (int i = 0; i < P; i++) begin
      if (rst_n && req_valid[i]) begin
        assert (int'(req_addr[i*AW +: AW]) < N);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_port_sram_banked.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_port_sram_banked
//  Purpose  : Self-checking bench for multi_port_sram_banked (P=2, BANKS=4,
//             N=256, W=32): directed scenarios followed by random traffic,
//             compared against a word-addressed reference memory with
//             per-bank round-robin pointers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_port_sram_banked;

  localparam int P     = 2;
  localparam int BANKS = 4;
  localparam int N     = 256;
  localparam int W     = 32;
  localparam int AW    = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [P-1:0]   req_valid = '0;
  logic [P-1:0]   req_ready;
  logic [P-1:0]   req_we = '0;
  logic [P*AW-1:0] req_addr = '0;
  logic [P*W-1:0] req_wdata = '0;
  logic [P-1:0]   rsp_valid;
  logic [P*W-1:0] rsp_rdata;

  always #5 clk = ~clk;

  multi_port_sram_banked #(.W(W), .N(N), .BANKS(BANKS), .P(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model
  logic [W-1:0]   mdl_mem [N];
  int             mdl_ptr [BANKS];
  logic [P-1:0]   mdl_vreg;
  logic [P*W-1:0] mdl_rdata;

  // Per-port requester state
  bit             pend    [P];
  bit             p_we    [P];
  logic [AW-1:0]  p_addr  [P];
  logic [W-1:0]   p_wdata [P];
  int             wait_cnt[P];
  bit             held    [P];
  logic [63:0]    held_val[P];
  logic [P-1:0]   last_ready;

  task automatic req(input int i, input bit we, input logic [AW-1:0] a, input logic [W-1:0] d);
    pend[i]     = 1'b1;
    p_we[i]     = we;
    p_addr[i]   = a;
    p_wdata[i]  = d;
    wait_cnt[i] = 0;
  endtask

  // One clock: drive inputs, check outputs, advance the model across the edge.
  task automatic cycle(input bit rst_level);
    logic [P-1:0] exp_ready;
    int win;
    int idx;
    rst_n = rst_level;
    for (int i = 0; i < P; i++) begin
      req_valid[i]          = pend[i];
      req_we[i]             = p_we[i];
      req_addr[i*AW +: AW]  = p_addr[i];
      req_wdata[i*W +: W]   = p_wdata[i];
    end
    #1;
    for (int i = 0; i < P; i++) begin
      if (held[i]) check("hold_stable", 64'({req_we[i], req_addr[i*AW +: AW], req_wdata[i*W +: W]}), held_val[i]);
    end
    check("rsp_valid", 64'(rsp_valid), 64'(mdl_vreg & {P{rst_level}}));
    check("rsp_rdata", rsp_rdata, mdl_rdata);

    exp_ready = '0;
    if (rst_level) begin
      for (int b = 0; b < BANKS; b++) begin
        win = -1;
        for (int k = 0; k < P; k++) begin
          idx = (mdl_ptr[b] + k) % P;
          if (win < 0 && pend[idx] && (int'(p_addr[idx]) % BANKS == b)) win = idx;
        end
        if (win >= 0) begin
          exp_ready[win] = 1'b1;
          mdl_ptr[b]     = (win + 1) % P;
        end
      end
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    last_ready = exp_ready;

    if (!rst_level) begin
      mdl_vreg  = '0;
      mdl_rdata = '0;
      for (int b = 0; b < BANKS; b++) mdl_ptr[b] = 0;
      for (int i = 0; i < P; i++) wait_cnt[i] = 0;
    end else begin
      for (int i = 0; i < P; i++) begin
        mdl_vreg[i] = exp_ready[i] && !p_we[i];
        if (exp_ready[i] && !p_we[i]) mdl_rdata[i*W +: W] = mdl_mem[p_addr[i]];
      end
      for (int i = 0; i < P; i++) begin
        if (exp_ready[i] && p_we[i]) mdl_mem[p_addr[i]] = p_wdata[i];
      end
    end

    for (int i = 0; i < P; i++) begin
      held[i]     = 1'b0;
      if (pend[i]) begin
        if (exp_ready[i]) begin
          check("starve_wait", 64'(wait_cnt[i] <= P - 1), 64'd1);
          pend[i] = 1'b0;
        end else begin
          if (rst_level) wait_cnt[i]++;
          held[i]     = 1'b1;
          held_val[i] = 64'({p_we[i], p_addr[i], p_wdata[i]});
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (pend[0] || pend[1]); n++) cycle(1'b1);
    check("drain_done", 64'(pend[0] || pend[1]), 64'd0);
    cycle(1'b1);
  endtask

  initial begin
    for (int i = 0; i < P; i++) begin
      pend[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
      wait_cnt[i] = 0; held[i] = 1'b0; held_val[i] = '0;
    end
    for (int b = 0; b < BANKS; b++) mdl_ptr[b] = 0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_rdata", rsp_rdata, 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    mdl_vreg  = '0;
    mdl_rdata = '0;

    // 1: write then read from the other port
    req(0, 1'b1, 8'h10, 32'hDEADBEEF);
    cycle(1'b1);
    check("t1_wr_ready", 64'(last_ready), 64'b01);
    req(1, 1'b0, 8'h10, '0);
    cycle(1'b1);
    check("t1_rsp_valid", 64'(rsp_valid), 64'b10);
    check("t1_rsp_rdata", 64'(rsp_rdata[63:32]), 64'hDEADBEEF);

    // 2: parallel accesses to different banks
    req(0, 1'b1, 8'h04, 32'hA);
    req(1, 1'b1, 8'h05, 32'hB);
    cycle(1'b1);
    req(0, 1'b0, 8'h04, '0);
    req(1, 1'b0, 8'h05, '0);
    cycle(1'b1);
    check("t2_ready", 64'(last_ready), 64'b11);
    check("t2_rsp_valid", 64'(rsp_valid), 64'b11);
    check("t2_rsp_rdata", rsp_rdata, 64'h0000000B_0000000A);

    // 3: continuous bank0 conflict from reset alternates grants
    cycle(1'b0);
    cycle(1'b0);
    for (int n = 0; n < 6; n++) begin
      if (!pend[0]) req(0, 1'b0, 8'h00, '0);
      if (!pend[1]) req(1, 1'b0, 8'h08, '0);
      cycle(1'b1);
      check("t3_alternate", 64'(last_ready), (n % 2 == 0) ? 64'b01 : 64'b10);
    end
    drain();

    // 4: same-address collision with ptr[bank0] = 1
    cycle(1'b0);
    req(0, 1'b1, 8'h20, 32'h7);
    cycle(1'b1);
    req(0, 1'b1, 8'h20, 32'h1);
    req(1, 1'b0, 8'h20, '0);
    cycle(1'b1);
    check("t4_first_grant", 64'(last_ready), 64'b10);
    cycle(1'b1);
    check("t4_second_grant", 64'(last_ready), 64'b01);
    check("t4_old_data", 64'(rsp_rdata[63:32]), 64'h7);
    req(1, 1'b0, 8'h20, '0);
    cycle(1'b1);
    check("t4_new_data", 64'(rsp_rdata[63:32]), 64'h1);

    // 5: reset right after a read is accepted
    req(0, 1'b0, 8'h10, '0);
    cycle(1'b1);
    check("t5_accept", 64'(last_ready), 64'b01);
    req(0, 1'b0, 8'h00, '0);
    req(1, 1'b0, 8'h08, '0);
    cycle(1'b0);
    check("t5_drop", 64'(rsp_valid), 64'd0);
    check("t5_ready_rst", 64'(req_ready), 64'd0);
    cycle(1'b1);
    check("t5_ptr_zero", 64'(last_ready), 64'b01);
    drain();

    // 6: opposite ends of the bank interleave
    req(0, 1'b1, 8'hFF, 32'h5A);
    req(1, 1'b1, 8'h00, 32'hA5);
    cycle(1'b1);
    check("t6_wr_ready", 64'(last_ready), 64'b11);
    req(0, 1'b0, 8'hFF, '0);
    req(1, 1'b0, 8'h00, '0);
    cycle(1'b1);
    check("t6_rsp_rdata", rsp_rdata, 64'h000000A5_0000005A);

    // Random traffic over a small, fully initialised window
    for (int a = 0; a < 32; a += 2) begin
      req(0, 1'b1, AW'(a), $urandom);
      req(1, 1'b1, AW'(a + 1), $urandom);
      cycle(1'b1);
    end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < P; i++) begin
        if (!pend[i] && $urandom_range(0, 9) < 7)
          req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
      end
      cycle(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_port_sram_banked.md
Name: multi_port_sram_banked

Overview:
- Parametrised P-port SRAM built from BANKS single-port banks with low-order address interleaving.
- Each bank services at most one access per cycle.
- Each bank has its own round-robin arbiter that resolves conflicts between ports, with a valid/ready request handshake and a fixed-latency read response.
- Serves as the shared multi-ported storage primitive under the memory library; replaces ad-hoc true-multiport arrays.

Parameters:
- W, 32, data width in bits.
- N, 256, total words; must be a multiple of BANKS.
- BANKS, 4, number of banks; power of 2, at least 1.
- P, 2, number of ports; at least 1.
- AW, $clog2(N), address width (derived; not overridable).

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  P  per-port request valid.
- req_ready  out  P  per-port request accepted this cycle.
- req_we  in  P  per-port write enable (1 = write, 0 = read).
- req_addr  in  P*AW  per-port word address; port i at [i*AW +: AW].
- req_wdata  in  P*W  per-port write data.
- rsp_valid  out  P  per-port read data valid.
- rsp_rdata  out  P*W  per-port read data.

Behaviour:
- Address mapping:
  - bank = addr[log2(BANKS)-1:0].
  - row = addr >> log2(BANKS).
  - Per-bank depth = N/BANKS.
  - BANKS=1 degenerates to a single bank with P-way arbitration.
- Handshake:
  - A request is accepted when req_valid[i] && req_ready[i] on a clk edge.
  - req_ready is combinational from req_valid/req_addr and arbiter state.
  - A requester holding valid must keep we/addr/wdata stable until accepted; the bench asserts this.
- Arbitration, per bank, each cycle:
  - Among ports requesting that bank, grant the first at or after ptr[bank] in increasing port order, wrapping modulo P.
  - req_ready is one-hot-or-zero per bank.
  - On a grant, ptr[bank] <= (winner+1) mod P; with no grant, ptr holds.
  - Ports targeting different banks are all granted in the same cycle.
- Write: the accepted write updates the bank row on the accepting edge. A read accepted in any later cycle returns the new data. No rsp_valid is produced for writes.
- Read:
  - Latency is exactly 1 cycle. rsp_valid[i] is high the cycle after acceptance and stays high for one cycle only.
  - rsp_rdata[i] holds the row contents as of before that edge's writes. No same-cycle conflict is possible, since a bank takes one access per cycle.
  - rsp_rdata holds its last value when rsp_valid is low.
- Reset (rst_n low at posedge):
  - rsp_valid = 0, rsp_rdata = 0, all ptr = 0, req_ready = 0 while rst_n is low.
  - Memory contents are not reset (X until written).
  - Reads accepted the cycle before reset is asserted are dropped: no rsp_valid.
- Boundary conditions:
  - Two ports to the same address in the same cycle are arbitrated like any other bank conflict.
  - Out-of-range addresses cannot occur, since N = 2^AW is required when N is a power of 2. For non-power-of-2 N, an address >= N is an assertion failure.
- Arbitration is starvation-free: a held request waits at most P-1 cycles.

Decomposition:
- multi_port_sram_pkg (extends the existing package):
  - bank_of/row_of address functions.
  - a rotate-priority helper function.
  - parameter sanity-check functions used by elaboration-time assertions.
- Sub-module multi_port_sram_rr_arb: P-input round-robin arbiter with pointer register and grant one-hot output. One instance per bank via generate. Each bank array is a generate-local reg array.

Test Plan (P=2, BANKS=4, N=256, W=32):
1. Write then read:
   - Stimulus: port0 writes 0x10 = 0xDEADBEEF (accepted cycle 0); port1 reads 0x10 at cycle 1.
   - Response: rsp_valid[1]=1 at cycle 2, rsp_rdata[1]=0xDEADBEEF; rsp_valid[0] stays 0.
2. Parallel, no conflict:
   - Stimulus: port0 reads 0x04 (bank0) and port1 reads 0x05 (bank1) in the same cycle, after pre-load 0xA, 0xB.
   - Response: req_ready=2'b11; next cycle rsp_valid=2'b11 with data 0xA, 0xB.
3. Conflict fairness:
   - Stimulus: both ports hold reads to bank0 (0x00, 0x08) continuously from reset.
   - Response: grants alternate port0, port1, port0, port1; req_ready is 2'b01/2'b10 alternating; no port waits more than 1 cycle.
4. Same-address collision:
   - Stimulus: ptr[bank0]=1; port0 writes 0x20 = 0x1 while port1 reads 0x20 (old value 0x7).
   - Response: port1 granted first and returns 0x7; port0 is granted the next cycle; a read after that returns 0x1.
5. Reset mid-operation:
   - Stimulus: read accepted at cycle k, rst_n=0 at the cycle k+1 edge.
   - Response: rsp_valid=0 at k+1; req_ready=0 during reset; after release, the bank0 conflict is granted to port0 first (ptr=0).
6. Bank wrap:
   - Stimulus: port0 writes 0xFF (bank3, row63) = 0x5A, port1 writes 0x00 (bank0, row0) = 0xA5 in the same cycle.
   - Response: both accepted; read-back returns 0x5A and 0xA5.
